// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 daisy-chain driver: register map,
// sequencer states and the serial word format.
package max7219_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] REG_NOOP         = 4'h0;
    localparam logic [3:0] REG_DIGIT0       = 4'h1;
    localparam logic [3:0] REG_DIGIT1       = 4'h2;
    localparam logic [3:0] REG_DIGIT2       = 4'h3;
    localparam logic [3:0] REG_DIGIT3       = 4'h4;
    localparam logic [3:0] REG_DIGIT4       = 4'h5;
    localparam logic [3:0] REG_DIGIT5       = 4'h6;
    localparam logic [3:0] REG_DIGIT6       = 4'h7;
    localparam logic [3:0] REG_DIGIT7       = 4'h8;
    localparam logic [3:0] REG_DECODE       = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } state_t;

    // One device word: upper nibble is don't-care on the part, driven as zero.
    function automatic logic [WORD_W-1:0] make_word(input logic [3:0] addr,
                                                    input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_chain_if.sv
// Host request/response and serial pin bundle for the MAX7219 chain driver.
interface max7219_chain_if #(
    parameter int DEV_W = 2
);
    logic             i_stb;
    logic [DEV_W-1:0] i_dev;
    logic             i_broadcast;
    logic [3:0]       i_addr;
    logic [7:0]       i_data;
    logic             o_busy;
    logic             o_ack;
    logic             o_serial_dout;
    logic             o_serial_load;
    logic             o_serial_clk;

    modport master (
        output i_stb, i_dev, i_broadcast, i_addr, i_data,
        input  o_busy, o_ack, o_serial_dout, o_serial_load, o_serial_clk
    );

    modport slave (
        input  i_stb, i_dev, i_broadcast, i_addr, i_data,
        output o_busy, o_ack, o_serial_dout, o_serial_load, o_serial_clk
    );
endinterface

// File: rtl/max7219_clk_div.sv
// Serial half-period timer: down-counter that ticks on terminal count and is
// re-armed whenever the sequencer changes state.
module max7219_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    // Reload on terminal count or state entry, otherwise count down.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear || tick) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/max7219_chain.sv
// MAX7219 daisy-chain driver: one host write becomes one full chain frame,
// with the addressed device getting the real word and the rest no-ops.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for a request, all pins low
// SHIFT_LO | serial clock low, current bit presented on DIN
// SHIFT_HI | serial clock high, devices sample DIN
// LOAD     | LOAD high after the last falling edge, chain latches
// DONE     | one-cycle ack; a new request may be taken here
module max7219_chain
    import max7219_pkg::*;
#(
    parameter int NUM_DEVICES = 4,
    parameter int CLK_DIV     = 2,
    parameter int DEV_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    max7219_chain_if.slave  bus
);
    localparam int FRAME_W = WORD_W * NUM_DEVICES;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d, frame;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic busy_q, busy_d, ack_q, ack_d, dout_q, dout_d;
    logic load_q, load_d, sclk_q, sclk_d;
    logic tick, accept;

    max7219_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear   (state_d != state_q),
        .tick    (tick)
    );

    assign accept = bus.i_stb && (state_q == ST_IDLE || state_q == ST_DONE);

    // Build the frame: device 0 sits in the LSBs so it is shifted out last.
    always_comb begin
        frame = '0;
        for (int d = 0; d < NUM_DEVICES; d++) begin
            if (bus.i_broadcast || (bus.i_dev == DEV_W'(d))) begin
                frame[d*WORD_W +: WORD_W] = make_word(bus.i_addr, bus.i_data);
            end
        end
    end

    // Sequencer next state plus next values of the registered pins.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_SHIFT_LO;
                    shreg_d = frame;
                    bit_d   = LAST_BIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (bit_q == '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q - 1'b1;
                    end
                end
            end
            ST_LOAD: if (tick) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) || (state_d == ST_LOAD);
        ack_d  = (state_d == ST_DONE);
        sclk_d = (state_d == ST_SHIFT_HI);
        load_d = (state_d == ST_LOAD);
        // DIN only moves when a low phase starts, so it is settled at each rising clock.
        dout_d = dout_q;
        if (state_d == ST_SHIFT_LO) begin
            dout_d = shreg_d[FRAME_W-1];
        end else if (state_d == ST_IDLE || state_d == ST_DONE) begin
            dout_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any frame before LOAD can rise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            dout_q  <= 1'b0;
            load_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            sclk_q  <= sclk_d;
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_ack         = ack_q;
    assign bus.o_serial_dout = dout_q;
    assign bus.o_serial_load = load_q;
    assign bus.o_serial_clk  = sclk_q;
endmodule
